// File: rtl/rule_depacker_param.sv
// rule_depacker_param: splits IN_W-bit packed rule beats into OUT_W-bit lanes (lane 0 first),
// optionally dropping all-zero lanes, and closes every packet with a zero-data eop terminator word.
module rule_depacker_param #(
    parameter int IN_W      = 128,
    parameter int OUT_W     = 64,
    parameter bit SKIP_ZERO = 1'b1,
    parameter bit EOP_DATA  = 1'b0,
    localparam int N    = IN_W / OUT_W,
    localparam int IE_W = $clog2(IN_W / 8),
    localparam int OE_W = (OUT_W > 8) ? $clog2(OUT_W / 8) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  in_rule_data,
    input  logic             in_rule_valid,
    output logic             in_rule_ready,
    input  logic             in_rule_sop,
    input  logic             in_rule_eop,
    input  logic [IE_W-1:0]  in_rule_empty,
    output logic [OUT_W-1:0] out_rule_data,
    output logic             out_rule_valid,
    input  logic             out_rule_ready,
    output logic             out_rule_sop,
    output logic             out_rule_eop,
    output logic [OE_W-1:0]  out_rule_empty
);
    localparam int XW = $clog2(N);
    localparam int LW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, LANES, TERM} state_e;

    state_e                  state_q;
    logic [N-1:0][OUT_W-1:0] buf_q;
    logic [XW-1:0]           idx_q;
    logic [LW-1:0]           lim_q;
    logic                    buf_eop_q, pend_sop_q, valid_q, sop_q, eop_q;
    logic [OUT_W-1:0]        data_q;

    logic             adv, last_lane, last_step, fire, step, emit, load;
    logic [OUT_W-1:0] lane;
    logic [IE_W:0]    eop_bytes;
    logic [LW-1:0]    eop_lim, lim_d;

    assign adv       = !valid_q || out_rule_ready;
    assign lane      = buf_q[idx_q];
    assign last_lane = LW'(idx_q) + LW'(1) == lim_q;
    assign last_step = state_q == TERM || (state_q == LANES && last_lane && !buf_eop_q);
    assign in_rule_ready = rst_n && (state_q == IDLE || (adv && last_step));
    assign fire      = in_rule_valid && in_rule_ready;
    assign step      = adv && state_q != IDLE;
    assign emit      = state_q == LANES && (!SKIP_ZERO || lane != '0);
    assign load      = step && (emit || state_q == TERM);

    // Only whole lanes on an eop beat are kept; a zero limit goes straight to the terminator.
    assign eop_bytes = (IE_W + 1)'(IN_W / 8) - {1'b0, in_rule_empty};
    assign eop_lim   = LW'(eop_bytes / (IE_W + 1)'(OUT_W / 8));
    assign lim_d     = !in_rule_eop ? LW'(N) : EOP_DATA ? eop_lim : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            idx_q      <= '0;
            lim_q      <= '0;
            buf_eop_q  <= 1'b0;
            pend_sop_q <= 1'b0;
            valid_q    <= 1'b0;
            sop_q      <= 1'b0;
            eop_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            if (adv) valid_q <= load;
            if (load) begin
                data_q <= emit ? lane : '0;
                sop_q  <= pend_sop_q;
                eop_q  <= !emit;
            end
            pend_sop_q <= (pend_sop_q && !load) || (fire && in_rule_sop);
            if (step && state_q == LANES) begin
                idx_q <= idx_q + XW'(1);
                if (last_lane) state_q <= buf_eop_q ? TERM : IDLE;
            end
            if (step && state_q == TERM) state_q <= IDLE;
            // A beat accepted on the last step overrides the IDLE transition for full throughput.
            if (fire) begin
                buf_q     <= in_rule_data;
                idx_q     <= '0;
                lim_q     <= lim_d;
                buf_eop_q <= in_rule_eop;
                state_q   <= lim_d == '0 ? TERM : LANES;
            end
        end
    end

    assign out_rule_data  = data_q;
    assign out_rule_valid = valid_q;
    assign out_rule_sop   = sop_q;
    assign out_rule_eop   = eop_q;
    assign out_rule_empty = '0;
endmodule

// File: tb/tb_rule_depacker_param.sv
// tb_rule_depacker_param: drives a 128->64 skip-zero instance and a 512->64 eop-data instance
// through one shared bus; a queue-based packet model scores every output handshake.
module tb_rule_depacker_param;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [511:0] idata = '0;
    logic         ivld = 1'b0, isop = 1'b0, ieop = 1'b0;
    logic [5:0]   iemp = '0;
    logic         ordy = 1'b1;
    logic         sel = 1'b0;
    logic         rand_rdy = 1'b0;

    logic        rdy_a, rdy_b, ov_a, ov_b, sop_a, sop_b, eop_a, eop_b;
    logic [63:0] od_a, od_b;
    logic [2:0]  oe_a, oe_b;
    logic        irdy, ov, osop, oeop;
    logic [63:0] od;
    logic [2:0]  oemp;

    int          n_chk = 0, n_fail = 0;
    logic [65:0] expq[$];
    logic [65:0] got[$];
    bit          pend[2];
    bit          stall_q = 1'b0;
    logic [66:0] held = '0;

    typedef struct {
        logic [127:0] d;
        logic         sop;
        logic         eop;
        int           n;
        logic [65:0]  w0;
        logic [65:0]  w1;
    } vec_t;
    vec_t tbl[8];

    rule_depacker_param #(.IN_W(128), .OUT_W(64), .SKIP_ZERO(1'b1), .EOP_DATA(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_rule_data(idata[127:0]), .in_rule_valid(ivld && !sel),
        .in_rule_ready(rdy_a), .in_rule_sop(isop), .in_rule_eop(ieop), .in_rule_empty(iemp[3:0]),
        .out_rule_data(od_a), .out_rule_valid(ov_a), .out_rule_ready(ordy),
        .out_rule_sop(sop_a), .out_rule_eop(eop_a), .out_rule_empty(oe_a));

    rule_depacker_param #(.IN_W(512), .OUT_W(64), .SKIP_ZERO(1'b0), .EOP_DATA(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_rule_data(idata), .in_rule_valid(ivld && sel),
        .in_rule_ready(rdy_b), .in_rule_sop(isop), .in_rule_eop(ieop), .in_rule_empty(iemp),
        .out_rule_data(od_b), .out_rule_valid(ov_b), .out_rule_ready(ordy),
        .out_rule_sop(sop_b), .out_rule_eop(eop_b), .out_rule_empty(oe_b));

    assign irdy = sel ? rdy_b : rdy_a;
    assign ov   = sel ? ov_b : ov_a;
    assign osop = sel ? sop_b : sop_a;
    assign oeop = sel ? eop_b : eop_a;
    assign od   = sel ? od_b : od_a;
    assign oemp = sel ? oe_b : oe_a;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Packet-level model: instance 1 never skips zero lanes and unpacks whole lanes of the eop beat.
    task automatic model_beat(input bit s, input logic [511:0] d, input bit sp, input bit e, input int emp);
        int nl;
        logic [63:0] lane;
        if (sp) pend[s] = 1'b1;
        nl = !e ? (s ? 8 : 2) : (s ? (64 - emp) / 8 : 0);
        for (int i = 0; i < nl; i++) begin
            lane = d[i*64 +: 64];
            if (s || lane != 64'h0) begin
                expq.push_back({pend[s], 1'b0, lane});
                pend[s] = 1'b0;
            end
        end
        if (e) begin
            expq.push_back({pend[s], 1'b1, 64'h0});
            pend[s] = 1'b0;
        end
    endtask

    task automatic send(input logic [511:0] d, input bit s, input bit e, input int emp);
        int k = 0;
        idata = d; isop = s; ieop = e; iemp = 6'(emp); ivld = 1'b1;
        @(negedge clk);
        while (!irdy && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("in_accept", 128'(irdy), 128'(1));
        @(posedge clk);
        model_beat(sel, d, s, e, emp);
        #1 ivld = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (expq.size() != 0 && k < 400) begin
            @(posedge clk);
            k++;
        end
        chk("drain", 128'(expq.size()), 128'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) stall_q = 1'b0;
        else begin
            if (stall_q) chk("stall_hold", 128'({ov, osop, oeop, od}), 128'(held));
            stall_q = ov && !ordy;
            held = {ov, osop, oeop, od};
            if (ov && ordy) begin
                got.push_back({osop, oeop, od});
                chk("out_empty", 128'(oemp), 128'(0));
                chk("word_expected", 128'(expq.size() != 0), 128'(1));
                if (expq.size() != 0) chk("out_word", 128'({osop, oeop, od}), 128'(expq.pop_front()));
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) ordy = $urandom_range(0, 3) != 0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [511:0] d;
        tbl[0] = '{128'h0000000000000002_0000000000000001, 1'b1, 1'b0, 2, {2'b10, 64'h1}, {2'b00, 64'h2}};
        tbl[1] = '{128'hDEADBEEF, 1'b0, 1'b1, 1, {2'b01, 64'h0}, 66'h0};
        tbl[2] = '{128'h0000000000000005_0000000000000000, 1'b1, 1'b0, 1, {2'b10, 64'h5}, 66'h0};
        tbl[3] = '{128'h0, 1'b0, 1'b1, 1, {2'b01, 64'h0}, 66'h0};
        tbl[4] = '{128'h123, 1'b1, 1'b1, 1, {2'b11, 64'h0}, 66'h0};
        tbl[5] = '{128'h0, 1'b1, 1'b0, 0, 66'h0, 66'h0};
        tbl[6] = '{128'h0000000000000007_0000000000000000, 1'b0, 1'b0, 1, {2'b10, 64'h7}, 66'h0};
        tbl[7] = '{{128{1'b1}}, 1'b0, 1'b1, 1, {2'b01, 64'h0}, 66'h0};

        #12;
        sel = 1'b0; #1;
        chk("rst_a_valid", 128'(ov), 128'(0));
        chk("rst_a_data", 128'(od), 128'(0));
        chk("rst_a_sop", 128'(osop), 128'(0));
        chk("rst_a_eop", 128'(oeop), 128'(0));
        chk("rst_a_inrdy", 128'(irdy), 128'(0));
        sel = 1'b1; #1;
        chk("rst_b_valid", 128'(ov), 128'(0));
        chk("rst_b_data", 128'(od), 128'(0));
        chk("rst_b_inrdy", 128'(irdy), 128'(0));
        sel = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back beats with ready high: 1(sop), 2, terminator on consecutive cycles.
        fork
            begin
                send(512'h0000000000000002_0000000000000001, 1'b1, 1'b0, 0);
                send(512'hFFFF, 1'b0, 1'b1, 0);
            end
            begin : tp
                int k = 0;
                @(negedge clk);
                while (!ov && k < 20) begin
                    @(negedge clk);
                    k++;
                end
                chk("tp_w0", 128'({ov, osop, oeop, od}), 128'({3'b110, 64'h1}));
                @(negedge clk);
                chk("tp_w1", 128'({ov, osop, oeop, od}), 128'({3'b100, 64'h2}));
                @(negedge clk);
                chk("tp_w2", 128'({ov, osop, oeop, od}), 128'({3'b101, 64'h0}));
            end
        join
        drain();

        foreach (tbl[i]) begin
            got.delete();
            send(512'(tbl[i].d), tbl[i].sop, tbl[i].eop, 0);
            repeat (6) @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_count", i), 128'(got.size()), 128'(tbl[i].n));
            if (tbl[i].n > 0) chk($sformatf("tbl%0d_w0", i), 128'(got[0]), 128'(tbl[i].w0));
            if (tbl[i].n > 1) chk($sformatf("tbl%0d_w1", i), 128'(got[1]), 128'(tbl[i].w1));
        end

        // Backpressure 1,0,0,1 across a 4-lane packet.
        fork
            begin
                send(512'h000000000000000B_000000000000000A, 1'b1, 1'b0, 0);
                send(512'h000000000000000D_000000000000000C, 1'b0, 1'b0, 0);
                send(512'h0, 1'b0, 1'b1, 0);
            end
            begin : bp
                int k = 0;
                @(negedge clk);
                while (!ov && k < 20) begin
                    @(negedge clk);
                    k++;
                end
                chk("bp_w0", 128'({ov, od}), 128'({1'b1, 64'hA}));
                @(posedge clk); #1 ordy = 1'b0;
                @(negedge clk);
                chk("bp_stall1", 128'({ov, od}), 128'({1'b1, 64'hB}));
                chk("bp_stall1_inrdy", 128'(irdy), 128'(0));
                @(posedge clk); #1;
                @(negedge clk);
                chk("bp_stall2", 128'({ov, od}), 128'({1'b1, 64'hB}));
                chk("bp_stall2_inrdy", 128'(irdy), 128'(0));
                @(posedge clk); #1 ordy = 1'b1;
            end
        join
        drain();

        // 512->64 eop-data instance: empty=40 keeps lanes 0..2 only.
        sel = 1'b1;
        got.delete();
        for (int i = 0; i < 8; i++) d[i*64 +: 64] = 64'(i + 1);
        send(d, 1'b1, 1'b1, 40);
        repeat (10) @(posedge clk);
        #1;
        chk("eopd_count", 128'(got.size()), 128'(4));
        chk("eopd_w0", 128'(got[0]), 128'({2'b10, 64'h1}));
        chk("eopd_w1", 128'(got[1]), 128'({2'b00, 64'h2}));
        chk("eopd_w2", 128'(got[2]), 128'({2'b00, 64'h3}));
        chk("eopd_w3", 128'(got[3]), 128'({2'b01, 64'h0}));

        got.delete();
        d = '0;
        d[127:64] = 64'h5;
        send(d, 1'b1, 1'b0, 0);
        repeat (12) @(posedge clk);
        #1;
        chk("noskip_count", 128'(got.size()), 128'(8));
        chk("noskip_w0", 128'(got[0]), 128'({2'b10, 64'h0}));
        chk("noskip_w1", 128'(got[1]), 128'({2'b00, 64'h5}));
        send(512'h0, 1'b0, 1'b1, 63);
        drain();

        // Asynchronous reset in the middle of an 8-lane beat.
        for (int i = 0; i < 8; i++) d[i*64 +: 64] = 64'(i + 1);
        send(d, 1'b1, 1'b0, 0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_valid", 128'(ov), 128'(0));
        chk("arst_data", 128'(od), 128'(0));
        chk("arst_sop", 128'(osop), 128'(0));
        chk("arst_eop", 128'(oeop), 128'(0));
        chk("arst_inrdy", 128'(irdy), 128'(0));
        expq.delete();
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_inrdy", 128'(irdy), 128'(1));
        got.delete();
        for (int i = 0; i < 8; i++) d[i*64 +: 64] = 64'(8'h11 * (i + 1));
        send(d, 1'b1, 1'b1, 48);
        repeat (8) @(posedge clk);
        #1;
        chk("post_rst_count", 128'(got.size()), 128'(3));
        chk("post_rst_w0", 128'(got[0]), 128'({2'b10, 64'h11}));
        chk("post_rst_w2", 128'(got[2]), 128'({2'b01, 64'h0}));

        rand_rdy = 1'b1;
        for (int p = 0; p < 30; p++) begin
            int nb;
            sel = 1'($urandom_range(0, 1));
            nb = $urandom_range(0, 3);
            for (int b = 0; b <= nb; b++) begin
                for (int i = 0; i < 8; i++)
                    d[i*64 +: 64] = ($urandom_range(0, 2) == 0) ? 64'h0 : {$urandom, $urandom};
                send(d, b == 0 && $urandom_range(0, 7) != 0, b == nb, $urandom_range(0, 63));
            end
            drain();
        end
        rand_rdy = 1'b0;
        ordy = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
